cic3_comp_fir_dec2: RTL and testbench
=====================================

# cic3_comp_fir_dec2

Post-CIC droop-compensation FIR with decimate-by-2. It sits directly downstream of the CIC3 decimator in the sigma-delta receive chain. It consumes signed 25-bit CIC output samples qualified by a valid strobe and emits 16-bit rounded, saturated samples at half the CIC output rate. A single multiply-accumulate unit is time-shared across the 7 taps under a small FSM.

## Interface
Parameters:
- IN_W, 25, input sample width (signed, two's complement).
- OUT_W, 16, output sample width (signed).
- ACC_W, 32, accumulator width.
- GAIN_SHIFT, 15, total right shift applied to the accumulator (6 for coefficient normalisation, 9 for width reduction).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- din  in  IN_W  CIC output sample, signed.
- din_valid  in  1  one-cycle strobe; din is accepted on any cycle where it is high.
- clear_overrun  in  1  synchronous clear of the overrun flag.
- mon_sel  in  2  digital monitor select.
- dout  out  OUT_W  filtered, decimated sample; held until the next result.
- dout_valid  out  1  one-cycle pulse marking a new dout.
- busy  out  1  high while a MAC sequence is in progress.
- overrun  out  1  sticky flag: a compute trigger was dropped.
- mon  out  ACC_W  digital monitor bus.

## Operation
- Coefficients are fixed, symmetric, and have a DC gain of 64: h[0..6] = -1, -3, 12, 48, 12, -3, -1. The sum of |h| is 80.
- Delay line: 7 × IN_W registers, with d[0] the newest. On din_valid, contents shift (d[k] <= d[k-1]) and d[0] <= din. The shift happens regardless of FSM state, so input is never stalled.
- Phase bit: toggles on each accepted sample and is reset to 0. A trigger is an accepted sample while phase = 1, i.e. every 2nd sample. The first trigger is the 2nd sample after reset.
- On a trigger with the FSM in IDLE:
  - snapshot s[0..6] <= post-shift delay line (includes the new sample);
  - acc <= 0, tap index <= 0, state <= MAC.
- On a trigger with the FSM not in IDLE:
  - the computation is dropped and overrun <= 1;
  - the delay line and phase still update.
- FSM states:
  - IDLE: wait for a trigger.
  - MAC: 7 cycles. Each cycle, acc += s[k]*h[k] (full sign extension) and k++. After k = 6, go to DONE.
  - DONE: 1 cycle. dout <= sat(( acc + 2^(GAIN_SHIFT-1) ) >>> GAIN_SHIFT), dout_valid <= 1 for the next cycle, state <= IDLE.
- Arithmetic:
  - sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Rounding is round-half-up (add the half-LSB, then arithmetic shift).
  - ACC_W = 32 guarantees no accumulator overflow for any IN_W = 25 input.
- busy = (state != IDLE).
- overrun clears on clear_overrun. If a new drop occurs in the same cycle as clear_overrun, the drop wins and overrun stays 1.
- mon_sel selects the monitor source:
  - 0: acc;
  - 1: d[0] sign-extended;
  - 2: 16-bit output count, zero-extended (increments on each dout_valid, wraps at 65535 to 0);
  - 3: {29'b0, overrun, state[1:0]}, with IDLE = 0, MAC = 1, DONE = 2.
- mon is combinational from registers.

## Timing
- Reset (asynchronous) clears all registers to 0:
  - delay line, snapshot, acc, phase, count;
  - dout = 0, dout_valid = 0, busy = 0, overrun = 0, state = IDLE, mon = 0.
- Reset mid-sequence aborts the sequence. No dout_valid follows, and the first trigger after release is again the 2nd sample.
- Trigger at cycle T (din_valid high, phase = 1):
  - busy high in cycles T+1..T+8;
  - MAC in T+1..T+7, DONE in T+8;
  - dout updates and dout_valid pulses in T+9.
- Latency from trigger strobe to dout_valid is 9 cycles. The minimum trigger spacing without overrun is 9 cycles.
- A trigger in cycle T+9, when the FSM is IDLE again, is accepted.
- dout_valid is never high for two consecutive cycles.

## Test plan
- **Reset:** assert reset asynchronously mid-clock. All outputs read 0 immediately; mon = 0 for every mon_sel.
- **Impulse:** din = 32768 then zeros, din_valid every 16 cycles. The dout sequence is -3, 48, -3, 0, 0. Each dout_valid arrives 9 cycles after the even-numbered strobe.
- **DC saturation:**
  - constant din = 16777215: from the 4th output onward, dout = 32767;
  - constant din = -16777216: dout = -32768;
  - constant din = 1000: dout = 2.
- **Overrun:** two triggers 4 cycles apart (strobes at T, T+2, T+4). Exactly one dout_valid at T+9 and overrun = 1. clear_overrun pulse -> overrun = 0. Simultaneous drop and clear -> overrun = 1.
- **Reset mid-MAC:** reset at T+4 after a trigger. No dout_valid occurs and dout = 0. After release, the 2nd new sample triggers and its result uses the cleared delay line.
- **Monitor:** after 3 outputs, mon_sel = 2 reads 3. While in MAC, mon_sel = 3 reads 1 (or 5 if overrun is set).

Source files
------------

// File: rtl/cic3_comp_fir_dec2.sv
// Droop-compensation FIR (7 symmetric taps) with decimate-by-2 behind the CIC3.
// One MAC is time-shared across the taps; results are rounded and saturated to OUT_W.
module cic3_comp_fir_dec2 #(
   parameter int IN_W       = 25,
   parameter int OUT_W      = 16,
   parameter int ACC_W      = 32,
   parameter int GAIN_SHIFT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [IN_W-1:0]  din,
   input  logic                    din_valid,
   input  logic                    clear_overrun,
   input  logic        [1:0]       mon_sel,
   output logic signed [OUT_W-1:0] dout,
   output logic                    dout_valid,
   output logic                    busy,
   output logic                    overrun,
   output logic        [ACC_W-1:0] mon
);

   localparam int NTAPS  = 7;
   localparam int COEF_W = 8;
   localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2**(GAIN_SHIFT-1));
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [ACC_W:0] MINV = ~MAXV;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nx;
   logic signed [IN_W-1:0]    r_d    [NTAPS];
   logic signed [IN_W-1:0]    r_snap [NTAPS];
   logic signed [ACC_W-1:0]   r_acc;
   logic        [2:0]         r_k;
   logic                      r_phase;
   logic signed [OUT_W-1:0]   r_dout;
   logic                      r_dout_valid;
   logic                      r_overrun;
   logic        [15:0]        r_cnt;

   logic                      w_trig;
   logic                      w_start;
   logic                      w_drop;
   logic signed [COEF_W-1:0]  w_coef;
   logic signed [ACC_W-1:0]   w_samp_ext;
   logic signed [ACC_W-1:0]   w_coef_ext;
   logic signed [ACC_W-1:0]   w_prod;

   function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] k);
      case (k)
         3'd0, 3'd6: return -8'sd1;
         3'd1, 3'd5: return -8'sd3;
         3'd2, 3'd4: return 8'sd12;
         3'd3:       return 8'sd48;
         default:    return 8'sd0;
      endcase
   endfunction

   // Round half up, arithmetic shift, clamp to the signed output range.
   function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      t = $signed({a[ACC_W-1], a}) + HALF;
      t = t >>> GAIN_SHIFT;
      if (t > MAXV)
         return MAXV[OUT_W-1:0];
      else if (t < MINV)
         return MINV[OUT_W-1:0];
      else
         return t[OUT_W-1:0];
   endfunction

   assign w_trig  = din_valid & r_phase;
   assign w_start = w_trig & (r_state == S_IDLE);
   assign w_drop  = w_trig & (r_state != S_IDLE);

   // Product is formed at accumulator width; |s*h| always fits.
   assign w_coef     = coef(r_k);
   assign w_samp_ext = {{(ACC_W-IN_W){r_snap[r_k][IN_W-1]}}, r_snap[r_k]};
   assign w_coef_ext = {{(ACC_W-COEF_W){w_coef[COEF_W-1]}}, w_coef};
   assign w_prod     = w_samp_ext * w_coef_ext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nx = S_MAC;
         S_MAC:   if (r_k == 3'd6) w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_d[i]    <= '0;
            r_snap[i] <= '0;
         end
         r_acc        <= '0;
         r_k          <= '0;
         r_phase      <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_cnt        <= '0;
      end else begin
         // Input is never stalled: the line shifts even while the MAC is busy.
         if (din_valid) begin
            r_d[0] <= din;
            for (int i = 1; i < NTAPS; i++)
               r_d[i] <= r_d[i-1];
            r_phase <= ~r_phase;
         end

         if (w_start) begin
            r_snap[0] <= din;
            for (int i = 1; i < NTAPS; i++)
               r_snap[i] <= r_d[i-1];
            r_acc <= '0;
            r_k   <= '0;
         end else if (r_state == S_MAC) begin
            r_acc <= r_acc + w_prod;
            r_k   <= (r_k == 3'd6) ? 3'd0 : r_k + 3'd1;
         end

         r_dout_valid <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_dout <= round_sat(r_acc);
            r_cnt  <= r_cnt + 16'd1;
         end

         // A drop in the same cycle as a clear keeps the flag set.
         if (w_drop)
            r_overrun <= 1'b1;
         else if (clear_overrun)
            r_overrun <= 1'b0;
      end
   end

   always_comb begin
      mon = '0;
      case (mon_sel)
         2'd0:    mon = r_acc;
         2'd1:    mon = {{(ACC_W-IN_W){r_d[0][IN_W-1]}}, r_d[0]};
         2'd2:    mon = {{(ACC_W-16){1'b0}}, r_cnt};
         2'd3:    mon = {{(ACC_W-3){1'b0}}, r_overrun, r_state};
         default: mon = '0;
      endcase
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign busy       = (r_state != S_IDLE);
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_cic3_comp_fir_dec2.sv
// Bench for cic3_comp_fir_dec2: directed vectors plus a cycle scoreboard fed by
// an arithmetic reference of the filter, decimation and trigger-spacing rules.
module tb_cic3_comp_fir_dec2;

   localparam int IN_W  = 25;
   localparam int OUT_W = 16;
   localparam int ACC_W = 32;
   localparam int GS    = 15;

   logic                    clk = 1'b0;
   logic                    reset;
   logic signed [IN_W-1:0]  din;
   logic                    din_valid;
   logic                    clear_overrun;
   logic        [1:0]       mon_sel;
   logic signed [OUT_W-1:0] dout;
   logic                    dout_valid;
   logic                    busy;
   logic                    overrun;
   logic        [ACC_W-1:0] mon;

   cic3_comp_fir_dec2 #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .GAIN_SHIFT(GS)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .clear_overrun(clear_overrun), .mon_sel(mon_sel), .dout(dout),
      .dout_valid(dout_valid), .busy(busy), .overrun(overrun), .mon(mon)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model
   int H[7] = '{-1, -3, 12, 48, 12, -3, -1};
   typedef struct { int t; int val; } ev_t;
   ev_t    expq[$];
   ev_t    gotq[$];
   int     hist[7];
   int     m_phase, m_last, m_dout, m_vld, m_ovr, m_cnt, m_drop;
   longint m_acc;
   int     cyc = 0;
   int     sb_d;
   int     last_cyc;

   function automatic int ref_out(input longint a);
      longint r;
      r = (a + (longint'(1) <<< (GS - 1))) >>> GS;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (hist[i]) hist[i] = 0;
         m_phase = 0; m_last = -100; m_acc = 0; m_dout = 0; m_vld = 0;
         m_ovr = 0; m_cnt = 0;
         expq.delete();
      end else begin
         cyc++;
         m_vld = 0;
         if (expq.size() > 0 && expq[0].t == cyc) begin
            m_dout = expq[0].val;
            m_vld  = 1;
            m_cnt++;
            void'(expq.pop_front());
         end
         m_drop = 0;
         if (din_valid) begin
            for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'($signed(din));
            if (m_phase == 1) begin
               if (cyc - m_last >= 9) begin
                  m_last = cyc;
                  m_acc  = 0;
                  for (int k = 0; k < 7; k++) m_acc += longint'(H[k]) * longint'(hist[k]);
                  expq.push_back('{cyc + 8, ref_out(m_acc)});
               end else begin
                  m_drop = 1;
               end
            end
            m_phase = 1 - m_phase;
         end
         if (m_drop == 1)    m_ovr = 1;
         else if (clear_overrun) m_ovr = 0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         sb_d = cyc - m_last;
         chk("sb_dout_valid", dout_valid, m_vld);
         chk("sb_dout", $signed(dout), m_dout);
         chk("sb_overrun", overrun, m_ovr);
         chk("sb_busy", busy, (sb_d >= 0 && sb_d <= 7));
         case (mon_sel)
            2'd0: if (sb_d >= 7) chk("sb_mon_acc", $signed(mon), m_acc);
            2'd1: chk("sb_mon_d0", $signed(mon), hist[0]);
            2'd2: chk("sb_mon_cnt", mon, m_cnt & 65535);
            default: chk("sb_mon_stat", mon,
                         m_ovr * 4 + ((sb_d >= 0 && sb_d <= 6) ? 1 : (sb_d == 7) ? 2 : 0));
         endcase
         if (dout_valid) gotq.push_back('{cyc, int'($signed(dout))});
      end
   end

   task automatic gap(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic strobe(input logic signed [IN_W-1:0] v);
      din = v;
      din_valid = 1'b1;
      @(posedge clk); #1;
      last_cyc = cyc;
      din_valid = 1'b0;
   endtask

   task automatic do_reset();
      din_valid = 1'b0; clear_overrun = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      #20;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reset_check(input string tag);
      logic [1:0] keep;
      keep = mon_sel;
      #1;
      chk({tag, "_dout"}, $signed(dout), 0);
      chk({tag, "_dout_valid"}, dout_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overrun"}, overrun, 0);
      for (int s = 0; s < 4; s++) begin
         mon_sel = 2'(s);
         #1;
         chk({tag, "_mon"}, mon, 0);
      end
      mon_sel = keep;
   endtask

   typedef struct { logic signed [IN_W-1:0] din; int exp_dout; } dc_t;
   dc_t dct[8];
   int  IMP[5] = '{-3, 48, -3, 0, 0};
   int  st[5];
   int  t0;
   int  dens;
   int  r;

   initial begin
      dct[0] = '{25'h0FFFFFF, 32767};
      dct[1] = '{25'h1000000, -32768};
      dct[2] = '{25'sd1000, 2};
      dct[3] = '{-25'sd1000, -2};
      dct[4] = '{25'sd256, 1};
      dct[5] = '{-25'sd256, 0};
      dct[6] = '{25'sd512, 1};
      dct[7] = '{25'sd16776704, 32767};

      din = '0; din_valid = 1'b0; clear_overrun = 1'b0; mon_sel = 2'd0; reset = 1'b0;
      #2 reset = 1'b1;
      reset_check("por");
      #20 reset = 1'b0;
      @(posedge clk); #1;

      // Impulse response
      do_reset();
      gotq.delete();
      for (int i = 0; i < 10; i++) begin
         strobe((i == 0) ? 25'sd32768 : 25'sd0);
         if (i % 2 == 1) st[i/2] = last_cyc;
         gap(15);
      end
      chk("imp_count", gotq.size(), 5);
      for (int i = 0; i < 5 && i < gotq.size(); i++) begin
         chk("imp_val", gotq[i].val, IMP[i]);
         chk("imp_latency", gotq[i].t - st[i] + 1, 9);
      end

      // DC gain, rounding and saturation
      for (int v = 0; v < 8; v++) begin
         do_reset();
         gotq.delete();
         repeat (16) begin strobe(dct[v].din); gap(9); end
         gap(6);
         chk("dc_count", gotq.size(), 8);
         if (gotq.size() == 8) begin
            chk("dc_4th", gotq[3].val, dct[v].exp_dout);
            chk("dc_last", gotq[7].val, dct[v].exp_dout);
         end
      end

      // Overrun
      do_reset();
      strobe(25'sd100);
      gap(3);
      gotq.delete();
      strobe(25'sd200);
      t0 = last_cyc;
      gap(1); strobe(25'sd300);
      gap(1); strobe(25'sd400);
      gap(12);
      chk("ovr_count", gotq.size(), 1);
      if (gotq.size() == 1) chk("ovr_latency", gotq[0].t - t0 + 1, 9);
      chk("ovr_set", overrun, 1);
      clear_overrun = 1'b1;
      @(posedge clk); #1;
      clear_overrun = 1'b0;
      chk("ovr_clear", overrun, 0);
      strobe(25'sd1); gap(1);
      strobe(25'sd2); gap(1);
      strobe(25'sd3); gap(1);
      clear_overrun = 1'b1;
      strobe(25'sd4);
      clear_overrun = 1'b0;
      chk("ovr_drop_wins", overrun, 1);
      gap(12);

      // Reset in the middle of a MAC sequence
      do_reset();
      gotq.delete();
      strobe(25'sd5000000); gap(2);
      strobe(25'sd6000000); gap(12);
      chk("rmac_pre_count", gotq.size(), 1);
      chk("rmac_pre_dout", $signed(dout), -641);
      strobe(25'sd7000000); gap(2);
      strobe(25'sd8000000); gap(3);
      chk("rmac_busy", busy, 1);
      #3;
      gotq.delete();
      reset = 1'b1;
      #1;
      chk("rmac_async_busy", busy, 0);
      chk("rmac_async_dout", $signed(dout), 0);
      #20 reset = 1'b0;
      @(posedge clk); #1;
      gap(15);
      chk("rmac_no_valid", gotq.size(), 0);
      chk("rmac_dout", $signed(dout), 0);
      strobe(25'sd1000000); gap(2);
      strobe(25'sd2000000); gap(12);
      chk("rmac_post_count", gotq.size(), 1);
      if (gotq.size() == 1) chk("rmac_post_val", gotq[0].val, -153);

      // Monitor
      do_reset();
      repeat (6) begin strobe(25'sd1000); gap(9); end
      gap(5);
      mon_sel = 2'd2;
      #1 chk("mon_count", mon, 3);
      mon_sel = 2'd3;
      strobe(25'sd1000); gap(1);
      strobe(25'sd1000);
      chk("mon_mac", mon, 1);
      gap(1); strobe(25'sd1000);
      gap(1); strobe(25'sd1000);
      chk("mon_mac_ovr", mon, 5);
      gap(10);
      mon_sel = 2'd0;

      // Randomized traffic against the scoreboard
      do_reset();
      for (int n = 0; n < 2500; n++) begin
         dens = (n < 1250) ? 2 : 9;
         din_valid = ($urandom_range(0, dens) == 0);
         r = $urandom_range(0, 7);
         din = (r == 0) ? 25'h0FFFFFF : (r == 1) ? 25'h1000000 : 25'($urandom);
         clear_overrun = ($urandom_range(0, 39) == 0);
         mon_sel = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      clear_overrun = 1'b0;
      gap(12);

      // Asynchronous reset mid-clock with live state
      strobe(25'sd12345); gap(1);
      strobe(25'sd54321); gap(2);
      #2 reset = 1'b1;
      reset_check("arst");
      #10 reset = 1'b0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no completion, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
